row_stream_tx: RTL and testbench
================================

Name: row_stream_tx

Overview:
- Host-side driver for the lane-detect NPU controller's byte-stream interface.
- Holds up to NUM_ROWS pixel rows of ROW_LEN bytes in a local buffer. For each row it pulses npu_start, streams the row bytes with npu_rx_valid, waits for npu_done, then captures the lane position and confidence as a per-row result.
- Sits between the system bus/test host and the NPU controller.

Parameters:
- ROW_LEN, 32: bytes per row. Must match the NPU row width.
- NUM_ROWS, 8: rows the buffer holds.
- GAP_CYCLES, 0: idle cycles inserted between consecutive valid bytes.
- TIMEOUT, 1023: maximum cycles to wait for npu_done.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- wr_en  input  1  buffer write strobe
- wr_addr  input  $clog2(NUM_ROWS*ROW_LEN)  byte address = row*ROW_LEN + pixel index
- wr_data  input  8  pixel byte
- go  input  1  start processing rows 0..num_rows-1
- num_rows  input  $clog2(NUM_ROWS)+1  number of rows to process
- busy  output  1  high while a sequence is in progress
- npu_start  output  1  one-cycle start pulse to the NPU
- npu_rx_data  output  8  pixel byte to the NPU
- npu_rx_valid  output  1  byte qualifier
- npu_tx_data  input  8  NPU lane position
- npu_confidence  input  8  NPU confidence
- npu_done  input  1  NPU result pulse
- res_valid  output  1  one-cycle pulse, result fields valid
- res_row  output  $clog2(NUM_ROWS)  row index of the result
- res_position  output  8  captured npu_tx_data
- res_confidence  output  8  captured npu_confidence
- all_done  output  1  one-cycle pulse at the end of a sequence
- timeout_err  output  1  sticky error flag, cleared on an accepted go

Behaviour:
- Reset domain: one clock; reset is asynchronous and active-low.
- Reset state while rst=0:
  - All outputs are 0 and the FSM is in IDLE.
  - Buffer contents are don't-care (not cleared).
- Buffer write:
  - A write occurs when wr_en=1 and busy=0.
  - wr_en while busy=1 is ignored, leaving the buffer unchanged.
  - A write to an address ≥ NUM_ROWS*ROW_LEN is ignored.
- FSM states: IDLE, START, SEND, GAP, WAIT_DONE, REPORT.
- IDLE:
  - go=1 with 1 ≤ num_rows ≤ NUM_ROWS: latch num_rows, row=0, clear timeout_err, go to START.
  - Any other go is ignored, and go is ignored while busy.
  - busy=1 in every state except IDLE.
- START:
  - npu_start=1 for exactly this one cycle.
  - Go to SEND with byte index=0.
- SEND:
  - npu_rx_valid=1 and npu_rx_data=buffer[row*ROW_LEN+idx], both registered outputs.
  - The first valid byte is in the cycle immediately after the npu_start cycle.
  - If idx==ROW_LEN-1, go to WAIT_DONE and clear the wait counter.
  - Otherwise idx++, then go to GAP if GAP_CYCLES>0, else stay in SEND.
  - With GAP_CYCLES=0 the row is ROW_LEN consecutive valid cycles.
- GAP:
  - npu_rx_valid=0 for GAP_CYCLES cycles, then return to SEND.
  - npu_rx_data holds its last value.
- WAIT_DONE:
  - npu_done=1: capture npu_tx_data→res_position and npu_confidence→res_confidence, go to REPORT.
  - Otherwise the counter increments.
  - When the counter reaches TIMEOUT: set timeout_err=1, pulse all_done in the next cycle, return to IDLE. No res_valid is issued for that row.
- REPORT:
  - res_valid=1 for one cycle, with res_row=row.
  - If row==num_rows-1: all_done=1 in the same cycle, go to IDLE.
  - Otherwise row++ and go to START. The next npu_start is 2 cycles after npu_done, which is legal because the NPU is back in IDLE the cycle after its done.
- npu_done outside WAIT_DONE is ignored.
- Result registers hold their value until the next capture.
- Per-row latency from npu_start to the last byte: ROW_LEN + (ROW_LEN-1)*GAP_CYCLES cycles.
- Asserting rst mid-sequence:
  - Immediately forces IDLE and drops npu_rx_valid, npu_start, busy and all pulse outputs to 0.
  - No partial result is reported.
- Counters wrap-free:
  - idx is sized to hold ROW_LEN-1.
  - The wait counter is sized to hold TIMEOUT and saturates at TIMEOUT.

Test Plan:
- Single row, GAP=0:
  - Stimulus: load row0 bytes 0x00..0x1F, go with num_rows=1, model NPU returns pos=0x0C, conf=0x80 after 40 cycles.
  - Required: one npu_start; 32 consecutive valid bytes 0x00..0x1F starting the next cycle; res_valid with row0/0x0C/0x80; all_done in the same cycle; busy low after.
- Three rows, GAP=2:
  - Required: each byte is followed by exactly 2 invalid cycles.
  - Required: res_row sequence 0,1,2.
  - Required: next npu_start exactly 2 cycles after each npu_done.
  - Required: all_done only with row 2.
- Timeout:
  - Stimulus: NPU never asserts done.
  - Required: timeout_err=1 after TIMEOUT wait cycles; all_done pulses; no res_valid.
  - Then: a new go clears timeout_err.
- Illegal and ignored commands:
  - Stimulus: go with num_rows=0, then num_rows=NUM_ROWS+1 → required: no npu_start, busy stays 0.
  - Stimulus: wr_en during SEND → required: streamed data unchanged.
  - Stimulus: go during busy → required: ignored.
- Reset mid-SEND (at byte 10):
  - Required: outputs 0 asynchronously.
  - Required: after release, a new go streams the full row from byte 0.
- Spurious npu_done during SEND:
  - Required: ignored; results captured only from the later done in WAIT_DONE.

Source files
------------

// File: rtl/row_stream_tx.sv
// Host-side row streamer for the lane-detect NPU: buffers pixel rows, streams each row as a
// byte stream, waits for the NPU result and reports it per row.
module row_stream_tx #(
    parameter int unsigned ROW_LEN    = 32,
    parameter int unsigned NUM_ROWS   = 8,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_en,
    input  logic [$clog2(NUM_ROWS*ROW_LEN)-1:0] wr_addr,
    input  logic [7:0]                          wr_data,
    input  logic                                go,
    input  logic [$clog2(NUM_ROWS):0]           num_rows,
    output logic                                busy,
    output logic                                npu_start,
    output logic [7:0]                          npu_rx_data,
    output logic                                npu_rx_valid,
    input  logic [7:0]                          npu_tx_data,
    input  logic [7:0]                          npu_confidence,
    input  logic                                npu_done,
    output logic                                res_valid,
    output logic [$clog2(NUM_ROWS)-1:0]         res_row,
    output logic [7:0]                          res_position,
    output logic [7:0]                          res_confidence,
    output logic                                all_done,
    output logic                                timeout_err
);
    localparam int unsigned DEPTH = NUM_ROWS * ROW_LEN;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned RW    = $clog2(NUM_ROWS);
    localparam int unsigned NW    = RW + 1;
    localparam int unsigned IW    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int unsigned GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StSend, StGap, StWaitDone, StReport
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [NW-1:0]   nrows_q, nrows_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic            terr_q, terr_d;
    logic            to_pulse_q, to_pulse_d;
    logic            rx_valid_q;
    logic [7:0]      rx_data_q, pos_q, conf_q;
    logic            capture, addr_ok, go_ok, last_row, last_byte;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      mem [DEPTH];

    // Only a non-power-of-two buffer can see out-of-range addresses.
    if ((1 << AW) > DEPTH) begin : g_addr_chk
        assign addr_ok = {1'b0, wr_addr} < (AW + 1)'(DEPTH);
    end else begin : g_addr_full
        assign addr_ok = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !busy && addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign go_ok     = go && (num_rows != '0) && (num_rows <= NW'(NUM_ROWS));
    assign last_row  = ({1'b0, row_q} == nrows_q - NW'(1));
    assign last_byte = (idx_q == IW'(ROW_LEN - 1));
    // Fetch with next-state indices so the byte lands in the same cycle as its valid.
    assign rd_addr   = AW'(row_d * ROW_LEN + idx_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            nrows_q    <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            wait_q     <= '0;
            terr_q     <= 1'b0;
            to_pulse_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            pos_q      <= '0;
            conf_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            nrows_q    <= nrows_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            wait_q     <= wait_d;
            terr_q     <= terr_d;
            to_pulse_q <= to_pulse_d;
            rx_valid_q <= (state_d == StSend);
            if (state_d == StSend) begin
                rx_data_q <= mem[rd_addr];
            end
            if (capture) begin
                pos_q  <= npu_tx_data;
                conf_q <= npu_confidence;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        nrows_d    = nrows_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        wait_d     = wait_q;
        terr_d     = terr_q;
        to_pulse_d = 1'b0;
        capture    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go_ok) begin
                    nrows_d = num_rows;
                    row_d   = '0;
                    terr_d  = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                idx_d   = '0;
                state_d = StSend;
            end
            StSend: begin
                if (last_byte) begin
                    wait_d  = '0;
                    state_d = StWaitDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? StGap : StSend;
                end
            end
            StGap: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = StSend;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (npu_done) begin
                    capture = 1'b1;
                    state_d = StReport;
                end else if (wait_q == TW'(TIMEOUT)) begin
                    terr_d     = 1'b1;
                    to_pulse_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StReport: begin
                if (last_row) begin
                    state_d = StIdle;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StStart;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy           = (state_q != StIdle);
        npu_start      = (state_q == StStart);
        res_valid      = (state_q == StReport);
        all_done       = to_pulse_q || ((state_q == StReport) && last_row);
        npu_rx_valid   = rx_valid_q;
        npu_rx_data    = rx_data_q;
        res_row        = row_q;
        res_position   = pos_q;
        res_confidence = conf_q;
        timeout_err    = terr_q;
    end

endmodule

// File: tb/tb_row_stream_tx.sv
// Bench for row_stream_tx: two instances (no gap / gap of 2) driven against a schedule model
// derived from row timing arithmetic, with a scripted NPU and random noise on the host side.
module tb_row_stream_tx;
    localparam int L   = 32;
    localparam int NR  = 8;
    localparam int TO  = 1023;
    localparam int WIN = 2048;

    typedef logic [39:0] vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en [2];
    logic [7:0] wr_addr, wr_data;
    logic       go [2];
    logic [3:0] num_rows;
    logic       busy [2], npu_start [2], rx_valid [2], npu_done [2];
    logic       res_valid [2], all_done [2], terr [2];
    logic [7:0] rx_data [2], tx_data [2], conf_in [2], res_pos [2], res_conf [2];
    logic [2:0] res_row [2];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        row_stream_tx #(.GAP_CYCLES(2 * i)) dut (
            .clk(clk), .rst(rst), .wr_en(wr_en[i]), .wr_addr(wr_addr), .wr_data(wr_data),
            .go(go[i]), .num_rows(num_rows), .busy(busy[i]), .npu_start(npu_start[i]),
            .npu_rx_data(rx_data[i]), .npu_rx_valid(rx_valid[i]), .npu_tx_data(tx_data[i]),
            .npu_confidence(conf_in[i]), .npu_done(npu_done[i]), .res_valid(res_valid[i]),
            .res_row(res_row[i]), .res_position(res_pos[i]), .res_confidence(res_conf[i]),
            .all_done(all_done[i]), .timeout_err(terr[i])
        );
    end

    // Reference state: buffer image and sticky error per instance.
    logic [7:0] mem_m [NR*L];
    bit         terr_m [2];

    // Per-cycle expectations and NPU/host stimulus for one sequence.
    vec_t       exp_v [WIN];
    bit         exp_dm [WIN];
    bit         d_done [WIN];
    bit         d_abuse [WIN];
    logic [7:0] d_pos [WIN], d_conf [WIN];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {conf, pos, row, data, busy, start, valid, res_valid, all_done, timeout_err}
    function automatic vec_t obs(input int d, input bit dm, input bit rm);
        vec_t v;
        v     = '0;
        v[0]  = terr[d];
        v[1]  = all_done[d];
        v[2]  = res_valid[d];
        v[3]  = rx_valid[d];
        v[4]  = npu_start[d];
        v[5]  = busy[d];
        if (dm) v[15:8] = rx_data[d];
        if (rm) begin
            v[18:16] = res_row[d];
            v[31:24] = res_pos[d];
            v[39:32] = res_conf[d];
        end
        return v;
    endfunction

    task automatic load(input bit ramp);
        for (int a = 0; a < NR * L; a++) begin
            @(negedge clk);
            wr_en[0] = 1'b1;
            wr_en[1] = 1'b1;
            wr_addr  = 8'(a);
            wr_data  = (ramp && a < L) ? 8'(a) : 8'($urandom);
            mem_m[a] = wr_data;
        end
        @(negedge clk);
        wr_en[0] = 1'b0;
        wr_en[1] = 1'b0;
    endtask

    task automatic bad_go(input int d, input int n);
        vec_t ev;
        ev    = '0;
        ev[0] = terr_m[d];
        @(negedge clk);
        go[d]    = 1'b1;
        num_rows = 4'(n);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            go[d] = 1'b0;
            check($sformatf("badgo d%0d n%0d c%0d", d, n, c), obs(d, 1'b0, 1'b0), ev);
        end
    endtask

    // dly: cycles from last byte to done (0 = random 1..6); pos/cnf < 0 = random.
    task automatic run_seq(input int d, input int nrows, input int dly, input int pos,
                           input int cnf, input bit never_done, input bit noise,
                           input int rst_at);
        int gap = 2 * d;
        int s, b, e, dc, last, endc;
        for (int c = 0; c < WIN; c++) begin
            exp_v[c]   = '0;
            exp_dm[c]  = 1'b0;
            d_done[c]  = 1'b0;
            d_abuse[c] = 1'b0;
            d_pos[c]   = 8'($urandom);
            d_conf[c]  = 8'($urandom);
        end
        s    = 1;
        last = 0;
        endc = 0;
        for (int r = 0; r < nrows; r++) begin
            exp_v[s][4] = 1'b1;
            for (int i = 0; i < L; i++) begin
                b = s + 1 + i * (gap + 1);
                exp_v[b][3] = 1'b1;
                for (int k = 0; k <= ((i == L - 1) ? 0 : gap); k++) begin
                    exp_dm[b + k]       = 1'b1;
                    exp_v[b + k][15:8]  = mem_m[r * L + i];
                end
                if (noise && i == 5) d_done[b] = 1'b1;
            end
            e = s + L + (L - 1) * gap;
            if (never_done) begin
                last           = e + 1 + TO;
                endc           = last + 1;
                exp_v[endc][1] = 1'b1;
                break;
            end
            dc = e + ((dly > 0) ? dly : int'($urandom_range(1, 6)));
            d_done[dc] = 1'b1;
            if (pos >= 0) d_pos[dc] = 8'(pos);
            if (cnf >= 0) d_conf[dc] = 8'(cnf);
            exp_v[dc + 1][2]     = 1'b1;
            exp_v[dc + 1][18:16] = 3'(r);
            exp_v[dc + 1][31:24] = d_pos[dc];
            exp_v[dc + 1][39:32] = d_conf[dc];
            if (r == nrows - 1) begin
                exp_v[dc + 1][1] = 1'b1;
                last             = dc + 1;
                endc             = dc + 2;
            end
            s = dc + 2;
        end
        for (int c = 1; c <= last; c++) exp_v[c][5] = 1'b1;
        exp_v[0][0] = terr_m[d];
        if (never_done) for (int c = endc; c < WIN; c++) exp_v[c][0] = 1'b1;
        if (noise) for (int c = 2; c <= last; c++) d_abuse[c] = ($urandom_range(0, 3) == 0);

        for (int c = 0; c <= endc + 1; c++) begin
            @(negedge clk);
            check($sformatf("d%0d c%0d", d, c), obs(d, exp_dm[c], exp_v[c][2]), exp_v[c]);
            if (c == rst_at) begin
                go[d]       = 1'b0;
                npu_done[d] = 1'b0;
                rst         = 1'b0;
                #1;
                check($sformatf("rst d0 c%0d", c), obs(0, 1'b1, 1'b1), '0);
                check($sformatf("rst d1 c%0d", c), obs(1, 1'b1, 1'b1), '0);
                terr_m[0] = 1'b0;
                terr_m[1] = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            go[d]       = (c == 0) || d_abuse[c];
            num_rows    = (c == 0) ? 4'(nrows) : (d_abuse[c] ? 4'($urandom) : num_rows);
            wr_en[d]    = d_abuse[c];
            wr_addr     = 8'($urandom);
            wr_data     = 8'($urandom);
            npu_done[d] = d_done[c];
            tx_data[d]  = d_pos[c];
            conf_in[d]  = d_conf[c];
        end
        go[d]       = 1'b0;
        wr_en[d]    = 1'b0;
        npu_done[d] = 1'b0;
        terr_m[d]   = never_done;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr_en[d]    = 1'b0;
            go[d]       = 1'b0;
            npu_done[d] = 1'b0;
            tx_data[d]  = '0;
            conf_in[d]  = '0;
            terr_m[d]   = 1'b0;
        end
        wr_addr  = '0;
        wr_data  = '0;
        num_rows = '0;
        #2 rst = 1'b0;
        #10;
        check("reset d0", obs(0, 1'b1, 1'b1), '0);
        check("reset d1", obs(1, 1'b1, 1'b1), '0);
        @(negedge clk);
        rst = 1'b1;

        load(1'b1);
        run_seq(0, 1, 8, 'h0C, 'h80, 1'b0, 1'b0, -1);
        run_seq(1, 3, 0, -1, -1, 1'b0, 1'b1, -1);
        bad_go(0, 0);
        bad_go(0, NR + 1);
        bad_go(1, 0);
        run_seq(0, 2, 0, -1, -1, 1'b1, 1'b1, -1);
        run_seq(0, NR, 0, -1, -1, 1'b0, 1'b1, -1);
        load(1'b0);
        run_seq(0, 1, 0, -1, -1, 1'b0, 1'b0, 12);
        run_seq(0, 1, 0, -1, -1, 1'b0, 1'b0, -1);
        for (int t = 0; t < 4; t++) begin
            run_seq(t % 2, int'($urandom_range(1, NR)), 0, -1, -1, 1'b0, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
